// File: rtl/gpu_pkg.sv
// Shared GPU front-end definitions: arbiter state encoding and stats counter width.
package gpu_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  localparam int STATS_W = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request searching upward from
// last_grant+1 with modulo-NUM_REQ wrap. Shared by the instruction and data arbiters.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/icache_arbiter.sv
// Round-robin arbiter sharing one instruction-cache fetch port among NUM_REQ fetchers.
// Define ICACHE_ARB_STATS_EN to add per-requester grant counters and a BUSY cycle counter.
module icache_arbiter
  import gpu_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_pc,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ*DATA_BITS-1:0]   req_instruction,
  output logic                           cache_valid,
  output logic [ADDR_BITS-1:0]           cache_pc,
  input  logic                           cache_ready,
  input  logic [DATA_BITS-1:0]           cache_instruction,
`ifdef ICACHE_ARB_STATS_EN
  output logic [NUM_REQ*STATS_W-1:0]     grant_count,
  output logic [STATS_W-1:0]             busy_cycles,
`endif
  output logic [1:0]                     dbg_state
);

  localparam int               IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  // Handshakes: the cache sees cache_valid held high with a stable cache_pc until it
  // answers with a one-cycle cache_ready; fetchers hold req_valid until their
  // one-cycle req_ready pulse, which always arrives the cycle after cache_ready.

  arb_state_e                   state_q, state_d;
  logic [IDX_W-1:0]             grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]             last_grant_q, last_grant_d;
  logic                         cache_valid_q, cache_valid_d;
  logic [ADDR_BITS-1:0]         cache_pc_q, cache_pc_d;
  logic [NUM_REQ-1:0]           req_ready_q, req_ready_d;
  logic [NUM_REQ*DATA_BITS-1:0] req_instr_q, req_instr_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .idx        (pick_idx),
    .found      (pick_found)
  );

  always_comb begin
    state_d       = state_q;
    grant_idx_d   = grant_idx_q;
    last_grant_d  = last_grant_q;
    cache_valid_d = cache_valid_q;
    cache_pc_d    = cache_pc_q;
    req_ready_d   = req_ready_q;
    req_instr_d   = req_instr_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_idx_d   = pick_idx;
          cache_pc_d    = req_pc[pick_idx*ADDR_BITS +: ADDR_BITS];
          cache_valid_d = 1'b1;
          state_d       = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (cache_ready) begin
          req_instr_d[grant_idx_q*DATA_BITS +: DATA_BITS] = cache_instruction;
          req_ready_d              = '0;
          req_ready_d[grant_idx_q] = 1'b1;
          cache_valid_d            = 1'b0;
          last_grant_d             = grant_idx_q;
          state_d                  = ARB_DONE;
        end
      end
      // Cooldown lets the served fetcher drop req_valid before the next scan.
      ARB_DONE: begin
        req_ready_d = '0;
        state_d     = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ARB_IDLE;
      grant_idx_q   <= '0;
      last_grant_q  <= LAST_RST;
      cache_valid_q <= 1'b0;
      cache_pc_q    <= '0;
      req_ready_q   <= '0;
      req_instr_q   <= '0;
    end else begin
      state_q       <= state_d;
      grant_idx_q   <= grant_idx_d;
      last_grant_q  <= last_grant_d;
      cache_valid_q <= cache_valid_d;
      cache_pc_q    <= cache_pc_d;
      req_ready_q   <= req_ready_d;
      req_instr_q   <= req_instr_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign req_instruction = req_instr_q;
  assign cache_valid     = cache_valid_q;
  assign cache_pc        = cache_pc_q;
  assign dbg_state       = state_q;

`ifdef ICACHE_ARB_STATS_EN
  logic [NUM_REQ*STATS_W-1:0] grant_count_q, grant_count_d;
  logic [STATS_W-1:0]         busy_cycles_q, busy_cycles_d;

  // Grant counters step on the same edge that raises the requester's req_ready.
  always_comb begin
    grant_count_d = grant_count_q;
    busy_cycles_d = busy_cycles_q;
    if (state_q == ARB_BUSY) begin
      busy_cycles_d = busy_cycles_q + STATS_W'(1);
      if (cache_ready) begin
        grant_count_d[grant_idx_q*STATS_W +: STATS_W] =
          grant_count_q[grant_idx_q*STATS_W +: STATS_W] + STATS_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_count_q <= '0;
      busy_cycles_q <= '0;
    end else begin
      grant_count_q <= grant_count_d;
      busy_cycles_q <= busy_cycles_d;
    end
  end

  assign grant_count = grant_count_q;
  assign busy_cycles = busy_cycles_q;
`endif

endmodule

// File: tb/tb_icache_arbiter.sv
// Self-checking bench for icache_arbiter: cycle-level fetcher/cache driver, round-robin
// reference model, and a scoreboard monitor checking each req_ready pulse.
module tb_icache_arbiter;
  import gpu_pkg::*;

  localparam int NUM_REQ   = 4;
  localparam int ADDR_BITS = 8;
  localparam int DATA_BITS = 16;
  localparam int EW        = 8 + DATA_BITS;

  logic                         clk = 1'b0;
  logic                         reset = 1'b1;
  logic [NUM_REQ-1:0]           req_valid = '0;
  logic [NUM_REQ*ADDR_BITS-1:0] req_pc = '0;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*DATA_BITS-1:0] req_instruction;
  logic                         cache_valid;
  logic [ADDR_BITS-1:0]         cache_pc;
  logic                         cache_ready = 1'b0;
  logic [DATA_BITS-1:0]         cache_instruction = '0;
  logic [1:0]                   dbg_state;
`ifdef ICACHE_ARB_STATS_EN
  logic [NUM_REQ*16-1:0]        grant_count;
  logic [15:0]                  busy_cycles;
`endif

  icache_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_pc            (req_pc),
    .req_ready         (req_ready),
    .req_instruction   (req_instruction),
    .cache_valid       (cache_valid),
    .cache_pc          (cache_pc),
    .cache_ready       (cache_ready),
    .cache_instruction (cache_instruction),
`ifdef ICACHE_ARB_STATS_EN
    .grant_count       (grant_count),
    .busy_cycles       (busy_cycles),
`endif
    .dbg_state         (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];
  int grant_log[$];

  // stimulus knobs
  bit auto_en = 0, keep_pc = 0, glitch_en = 0, cache_hold = 0, data_fixed_en = 0;
  int idle_max = 0, lat_min = 0, lat_max = 0;
  logic [DATA_BITS-1:0] data_fixed = '0;

  // reference model state
  bit window_open = 0, open_next = 0, cv_prev = 0;
  int last_served = NUM_REQ - 1;
  int cur_idx = 0, lat_cnt = 0;
  logic [ADDR_BITS-1:0] cur_pc = '0;
  int idle_cnt[NUM_REQ];
  logic [15:0] busy_model = '0;
  int gcnt_model[NUM_REQ];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Round-robin rule: first pending requester after the last one served, wrapping.
  function automatic int rr_model(input logic [NUM_REQ-1:0] v, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic raise(input int i, input logic [ADDR_BITS-1:0] pc);
    req_valid[i] = 1'b1;
    req_pc[i*ADDR_BITS +: ADDR_BITS] = pc;
  endtask

  // One cycle: observe grant/cache side at negedge, then drive cache and fetchers.
  task automatic tick();
    int w;
    logic [DATA_BITS-1:0] d;
    @(negedge clk);
    if (window_open) begin
      check("grant_window", 64'(cache_valid), 64'(|req_valid));
      if (cache_valid) begin
        window_open = 1'b0;
        w = rr_model(req_valid, last_served);
        if (w >= 0) begin
          cur_idx     = w;
          cur_pc      = req_pc[w*ADDR_BITS +: ADDR_BITS];
          last_served = w;
          grant_log.push_back(w);
        end
        lat_cnt = $urandom_range(lat_max, lat_min);
      end
    end else if (cache_valid && !cv_prev) begin
      check("spurious_grant", 64'(cache_valid), 64'(0));
    end
    if (cache_valid) begin
      check("cache_pc", 64'(cache_pc), 64'(cur_pc));
      busy_model++;
    end
    if (cache_ready) begin
      check("cache_valid_fall", 64'(cache_valid), 64'(0));
      cache_ready = 1'b0;
    end else if (cache_valid && !cache_hold) begin
      if (lat_cnt == 0) begin
        d = data_fixed_en ? data_fixed : DATA_BITS'($urandom);
        cache_ready       = 1'b1;
        cache_instruction = d;
        exp_q.push_back({8'(cur_idx), d});
        gcnt_model[cur_idx]++;
      end else begin
        lat_cnt--;
      end
    end
    if (open_next) begin
      window_open = 1'b1;
      open_next   = 1'b0;
    end
    if (req_ready != '0) open_next = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        req_valid[i] = 1'b0;
        idle_cnt[i]  = $urandom_range(idle_max, 0);
      end else if (!req_valid[i] && auto_en) begin
        if (idle_cnt[i] == 0) begin
          req_valid[i] = 1'b1;
          if (!keep_pc) req_pc[i*ADDR_BITS +: ADDR_BITS] = ADDR_BITS'($urandom);
        end else begin
          idle_cnt[i]--;
        end
      end
    end
    if (glitch_en && cache_valid) req_pc = (NUM_REQ*ADDR_BITS)'($urandom);
    cv_prev = cache_valid;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    check("rst_cache_valid", 64'(cache_valid), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(ARB_IDLE));
    check("rst_cache_pc", 64'(cache_pc), 64'(0));
    reset       = 1'b0;
    cache_ready = 1'b0;
    window_open = 1'b1;
    open_next   = 1'b0;
    cv_prev     = 1'b0;
    exp_q.delete();
    last_served = NUM_REQ - 1;
    busy_model  = '0;
    for (int i = 0; i < NUM_REQ; i++) gcnt_model[i] = 0;
  endtask

  task automatic wait_grants(input int n, input int maxc);
    int c = 0;
    while (grant_log.size() < n && c < maxc) begin
      tick();
      c++;
    end
    check("grant_timeout", 64'(grant_log.size() >= n), 64'(1));
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    int q = 0;
    while (q < 3 && c < maxc) begin
      tick();
      c++;
      if (req_valid == '0 && !cache_valid && req_ready == '0 && !cache_ready) q++;
      else q = 0;
    end
    check("drain_timeout", 64'(q >= 3), 64'(1));
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic [NUM_REQ-1:0]           rdy_prev;
    logic [NUM_REQ*DATA_BITS-1:0] instr_exp;
    logic [EW-1:0]                e;
    int                           idx;
    rdy_prev  = '0;
    instr_exp = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        check("rst_instruction", 64'(req_instruction), 64'(0));
        instr_exp = '0;
        rdy_prev  = '0;
      end else begin
        if (rdy_prev != '0) begin
          check("ready_pulse_width", 64'(req_ready), 64'(0));
        end else if (req_ready != '0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_ready", 64'(req_ready), 64'(0));
          end else begin
            e   = exp_q.pop_front();
            idx = int'(e[EW-1:DATA_BITS]);
            check("ready_onehot", 64'(req_ready), 64'(NUM_REQ'(1) << idx));
            instr_exp[idx*DATA_BITS +: DATA_BITS] = e[DATA_BITS-1:0];
            check("instruction", 64'(req_instruction), 64'(instr_exp));
          end
        end
        rdy_prev = req_ready;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    for (int i = 0; i < NUM_REQ; i++) begin
      idle_cnt[i]   = 0;
      gcnt_model[i] = 0;
    end
    do_reset();

    // Single request, one-cycle miss with fixed data.
    lat_min = 1; lat_max = 1; data_fixed_en = 1; data_fixed = 16'hABCD;
    raise(2, 8'h15);
    wait_grants(1, 20);
    check("a_cache_pc", 64'(cache_pc), 64'h15);
    drain(50);
    check("a_instr2", 64'(req_instruction[2*DATA_BITS +: DATA_BITS]), 64'hABCD);
    check("a_pc_hold", 64'(cache_pc), 64'h15);

    // All four continuously requesting, instant hits.
    do_reset();
    grant_log.delete();
    data_fixed_en = 0; lat_min = 0; lat_max = 0;
    auto_en = 1; keep_pc = 1; idle_max = 0;
    for (int i = 0; i < NUM_REQ; i++) raise(i, 8'((i + 1) * 16));
    wait_grants(5, 100);
    auto_en = 0;
    drain(100);
    for (int k = 0; k < 5; k++) check("b_order", 64'(grant_log[k]), 64'(k % NUM_REQ));

    // Wrap: serve 3, then 1 and 3 pending.
    grant_log.delete();
    raise(3, 8'h33);
    drain(50);
    raise(1, 8'h11);
    raise(3, 8'h34);
    drain(50);
    check("wrap_first", 64'(grant_log[1]), 64'(1));
    check("wrap_second", 64'(grant_log[2]), 64'(3));

    // PC change while BUSY is ignored.
    lat_min = 4; lat_max = 4;
    grant_log.delete();
    raise(1, 8'h22);
    wait_grants(1, 20);
    req_pc[1*ADDR_BITS +: ADDR_BITS] = 8'h99;
    repeat (3) tick();
    check("c_pc_stable", 64'(cache_pc), 64'h22);
    drain(50);

    // Randomized traffic with random latencies and PC churn during BUSY.
    lat_min = 0; lat_max = 4; idle_max = 3;
    auto_en = 1; keep_pc = 0; glitch_en = 1;
    repeat (400) tick();
    auto_en = 0; glitch_en = 0;
    drain(200);

    // Reset while a fetch is outstanding.
    cache_hold = 1;
    grant_log.delete();
    raise(2, 8'h40);
    wait_grants(1, 20);
    raise(0, 8'h01);
    raise(1, 8'h02);
    raise(3, 8'h03);
    tick();
    tick();
    do_reset();
    cache_hold = 0;
    lat_min = 1; lat_max = 2;
    grant_log.delete();
    wait_grants(1, 20);
    check("e_first_after_reset", 64'(grant_log[0]), 64'(0));
    drain(100);

`ifdef ICACHE_ARB_STATS_EN
    do_reset();
    lat_min = 0; lat_max = 3;
    repeat (5) begin
      raise(0, 8'($urandom));
      drain(50);
    end
    repeat (2) begin
      raise(3, 8'($urandom));
      drain(50);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      check("grant_count", 64'(grant_count[i*16 +: 16]), 64'((i == 0) ? 5 : (i == 3) ? 2 : 0));
    end
    check("busy_cycles", 64'(busy_cycles), 64'(busy_model));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_arbiter.md
# icache_arbiter

Round-robin arbiter sharing the single instruction-cache fetch port between `NUM_REQ` core fetchers. It sits between the per-core fetchers and the instruction cache. Per grant it latches the winner's PC, drives the cache's valid/ready handshake, and returns the instruction to the winning fetcher as a one-cycle ready pulse. Exactly one fetch is in flight at any time.

## Interface
Parameters:
- `NUM_REQ`, 4: number of fetchers; ≥2.
- `ADDR_BITS`, 8: program address width.
- `DATA_BITS`, 16: instruction width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `req_valid` in `NUM_REQ`: per-fetcher request; held high until that fetcher's `req_ready` pulse.
- `req_pc` in `NUM_REQ*ADDR_BITS`: packed PCs; fetcher i uses slice `[i*ADDR_BITS +: ADDR_BITS]`.
- `req_ready` out `NUM_REQ`: one-cycle completion pulse, one-hot.
- `req_instruction` out `NUM_REQ*DATA_BITS`: packed per-fetcher instruction registers.
- `cache_valid` out 1: request to cache.
- `cache_pc` out `ADDR_BITS`: latched PC of the granted fetcher.
- `cache_ready` in 1: cache completion pulse.
- `cache_instruction` in `DATA_BITS`: cache data, valid while `cache_ready`=1.

## Operation
- States:
  - IDLE: scan for a request.
  - BUSY: a fetch is outstanding at the cache.
  - DONE: one-cycle cooldown.
- IDLE, any `req_valid` set:
  - Winner is the first set bit searching upward from `last_grant+1`, with modulo-`NUM_REQ` wrap.
  - Latch `grant_idx` and `cache_pc` ← that fetcher's PC.
  - `cache_valid` ← 1, go to BUSY.
- IDLE, no request: stay in IDLE; all outputs hold.
- BUSY:
  - `cache_valid` and `cache_pc` are held stable.
  - Changes on `req_pc` or `req_valid` are ignored.
  - On `cache_ready`:
    - `req_instruction[grant_idx]` ← `cache_instruction`.
    - `req_ready[grant_idx]` ← 1.
    - `cache_valid` ← 0.
    - `last_grant` ← `grant_idx`.
    - Go to DONE.
- DONE:
  - `req_ready` ← 0; go to IDLE.
  - No arbitration happens in DONE. This gives the served fetcher time to drop `req_valid` before the next scan.
- Other fetchers' `req_instruction` slices keep their last values.
- Requester withdrawal mid-grant is a protocol violation. The arbiter still completes the fetch and still pulses ready.
- Reset values:
  - State IDLE.
  - `cache_valid`, `cache_pc`, `req_ready`, `req_instruction` all 0.
  - `last_grant` = `NUM_REQ-1`, so requester 0 wins first.
- Reset mid-BUSY aborts the fetch with no ready pulse. The cache is reset in the same cycle.

## Timing
- Request first high in IDLE at cycle 0 → `cache_valid` high in cycle 1.
- Cache hit:
  - `cache_ready` in cycle 3.
  - `req_ready` in cycle 4.
  - Arbiter back in IDLE in cycle 5.
- Cache miss: `req_ready` follows `cache_ready` by one cycle, whatever the memory latency.
- `cache_valid` falls in the cycle right after `cache_ready`. The cache therefore never sees a stale request.
- Back-to-back service: new `cache_valid` at the earliest 2 cycles after `req_ready`.
- Fairness: with all requesters continuously active, each is served once every `NUM_REQ` grants.

## Configuration
- `ICACHE_ARB_STATS_EN` defined:
  - Adds output `grant_count`, width `NUM_REQ*16`: per-requester 16-bit grant counters. Each increments when that requester's `req_ready` pulses and wraps at 0xFFFF→0.
  - Adds output `busy_cycles`, 16 bits, wrapping: counts cycles spent in BUSY.
  - All counters reset to 0.
- Undefined: these ports and counters do not exist. Functional behaviour is identical either way.

## Structure
- Shared package `gpu_pkg` holds:
  - The arbiter state enum (IDLE/BUSY/DONE).
  - The stats counter width constant (16).
- Sub-module `rr_pick`: combinational round-robin priority picker.
  - Inputs: request vector and `last_grant`.
  - Outputs: index and found flag.
  - Reusable by the data-memory arbiter.

## Test plan
- Single request: fetcher 2, PC 0x15, cache returns 0xABCD after one miss → `cache_pc`=0x15, then `req_ready`=0b0100 for exactly one cycle, then `req_instruction[2]`=0xABCD.
- All four requesting, PCs 0x10/0x20/0x30/0x40, instant-hit cache model → grant order 0,1,2,3,0, and each fetcher receives its own data.
- After serving 3, requesters 1 and 3 pending → grant 1 (wrap). Requester 3 is held at the head of the next scan only if it is requested again.
- Fetcher 1 changes `req_pc` to 0x99 while BUSY on 0x22 → `cache_pc` stays 0x22.
- Reset asserted mid-BUSY → next cycle `cache_valid`=0, `req_ready`=0, state IDLE, and requester 0 is granted first afterwards.
- With `ICACHE_ARB_STATS_EN`: 5 grants to fetcher 0 and 2 to fetcher 3 → `grant_count` slices read 5,0,0,2, and `busy_cycles` equals the sum of BUSY durations.
